// File: rtl/nios_mul_pkg.sv
// nios_mul_pkg: shared types and widths for the multiply scheduler
package nios_mul_pkg;
  localparam int MUL_W = 32;
  localparam int HALF_W = 16;
  typedef enum logic [1:0] {IDLE, MUL, SUM, RSP} state_t;
endpackage

// File: rtl/nios_rr_arbiter.sv
// nios_rr_arbiter: round-robin pick of the first request at or after ptr
module nios_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               hit
);
  logic [IDW-1:0] lo_idx, hi_idx;
  logic hi_hit;
  // descending scan leaves the lowest valid index overall and the lowest at or after ptr
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_hit = 1'b0;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    idx = hi_hit ? hi_idx : lo_idx;
    grant = hit ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/nios_mul_sched.sv
// nios_mul_sched: shares one three-partial-product multiplier cell among requesters
module nios_mul_sched
  import nios_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_W-1:0] req_src2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [MUL_W-1:0]         rsp_result,
  output logic [MUL_W-1:0]         mul_src1,
  output logic [MUL_W-1:0]         mul_src2,
  output logic                     mul_en,
  input  logic [MUL_W-1:0]         mul_p1,
  input  logic [MUL_W-1:0]         mul_p2,
  input  logic [MUL_W-1:0]         mul_p3,
  output logic                     busy,
  output logic [15:0]              op_count
);
  state_t state, state_n;
  logic [IDW-1:0] ptr, idx, id_q;
  logic [NUM_REQ-1:0] grant;
  logic hit;
  logic [MUL_W-1:0] sel1, sel2, src1_q, src2_q, result_q, fold;
  logic [HALF_W-1:0] mid;
  logic unused_hi;

  nios_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .hit(hit)
  );

  // cross terms only reach the low word through their low halves
  assign mid = mul_p2[HALF_W-1:0] + mul_p3[HALF_W-1:0];
  assign fold = mul_p1 + {mid, {HALF_W{1'b0}}};
  assign unused_hi = ^{mul_p2[MUL_W-1:HALF_W], mul_p3[MUL_W-1:HALF_W]};
  assign mul_src1 = src1_q;
  assign mul_src2 = src2_q;
  assign rsp_id = id_q;
  assign rsp_result = result_q;

  // operand mux for the arbitration winner
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDW'(i)) begin
        sel1 = req_src1[i*MUL_W +: MUL_W];
        sel2 = req_src2[i*MUL_W +: MUL_W];
      end
    end
  end

  // next state and per-state outputs; grants are masked while reset is held
  always_comb begin
    state_n = state == IDLE ? (hit ? MUL : IDLE) :
              state == MUL  ? SUM :
              state == SUM  ? RSP :
              (rsp_ready ? IDLE : RSP);
    req_ready = (state == IDLE && !reset) ? grant : '0;
    mul_en = state == MUL;
    rsp_valid = state == RSP;
    busy = state != IDLE;
  end

  // state, operand latch, folded result and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      id_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      result_q <= '0;
      op_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && hit) begin
        ptr <= (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        id_q <= idx;
        src1_q <= sel1;
        src2_q <= sel2;
      end
      if (state == SUM) result_q <= fold;
      if (state == RSP && rsp_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule
